// File: rtl/ser_spi_iw_rx.sv
// rtl/ser_spi_iw_rx.sv - SPI mode-0 slave byte receiver with frame-marker detection
//
// Purpose:
//   Oversamples the host SPI pins (sclk/mosi/ss) in the clk domain and assembles
//   MSB-first words. Each completed word appears on dout_iw with a one-cycle
//   done_iw strobe. Two consecutive MARKER words close a frame (frame_end).
//   The grid result byte on din is returned to the host on miso, MSB first.
//
// Ports:
//   clk        in   system clock (sclk must be <= clk/4)
//   rst        in   asynchronous active-low reset
//   sclk       in   SPI clock from host (async)
//   mosi       in   SPI data from host (async)
//   ss         in   SPI slave select, active low (async)
//   din        in   result word, sampled at each word start
//   miso       out  SPI data to host, 0 while deselected
//   dout_iw    out  last complete received word
//   done_iw    out  one-cycle strobe, dout_iw updated
//   frame_end  out  one-cycle strobe on the second consecutive MARKER
//   byte_cnt   out  words accepted since reset or last frame_end

module ser_spi_iw_rx #(
   parameter int                DATA_W      = 8,
   parameter int                SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0] MARKER      = DATA_W'(128),
   parameter int                CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              mosi,
   input  logic              ss,
   input  logic [DATA_W-1:0] din,
   output logic              miso,
   output logic [DATA_W-1:0] dout_iw,
   output logic              done_iw,
   output logic              frame_end,
   output logic [CNT_W-1:0]  byte_cnt
);

   localparam int              BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Pin synchronizers plus one extra stage on sclk/ss for edge detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] ss_sync_q,   ss_sync_d;
   logic                   sclk_dly_q,  sclk_dly_d;
   logic                   ss_dly_q,    ss_dly_d;

   logic sclk_s, mosi_s, ss_s;
   logic sclk_rise, sclk_fall, ss_fall;

   always_comb begin
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
      sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
      ss_dly_d    = ss_sync_q[SYNC_STAGES-1];
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_dly_q;
   assign sclk_fall = ~sclk_s & sclk_dly_q;
   assign ss_fall   = ~ss_s & ss_dly_q;

   // Idle levels after reset: sclk low, ss high, so no false edge is seen.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         ss_sync_q   <= '1;
         sclk_dly_q  <= 1'b0;
         ss_dly_q    <= 1'b1;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         ss_sync_q   <= ss_sync_d;
         sclk_dly_q  <= sclk_dly_d;
         ss_dly_q    <= ss_dly_d;
      end
   end

   // ------------------------------------------------------------------
   // Protocol state
   // ------------------------------------------------------------------
   state_t             state_q,    state_d;
   logic [BIT_W-1:0]   bit_cnt_q,  bit_cnt_d;
   logic [DATA_W-1:0]  rx_sr_q,    rx_sr_d;
   logic [DATA_W-1:0]  tx_sr_q,    tx_sr_d;
   logic               miso_q,     miso_d;
   logic [DATA_W-1:0]  dout_q,     dout_d;
   logic               done_q,     done_d;
   logic               fe_q,       fe_d;
   logic               mk_q,       mk_d;
   logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
   logic [DATA_W-1:0]  rx_word;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_sr_d    = rx_sr_q;
      tx_sr_d    = tx_sr_q;
      miso_d     = miso_q;
      dout_d     = dout_q;
      done_d     = 1'b0;
      fe_d       = 1'b0;
      mk_d       = mk_q;
      byte_cnt_d = byte_cnt_q;
      rx_word    = {rx_sr_q[DATA_W-2:0], mosi_s};

      case (state_q)
         IDLE: begin
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            if (ss_fall) begin
               state_d = SHIFT;
               tx_sr_d = din;
               miso_d  = din[DATA_W-1];
            end
         end

         SHIFT: begin
            // Deselect has priority over a coincident sclk rise; any partial
            // word is dropped without touching dout_iw or byte_cnt.
            if (ss_s) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
               miso_d    = 1'b0;
            end else if (sclk_rise) begin
               rx_sr_d = rx_word;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  dout_d    = rx_word;
                  done_d    = 1'b1;
                  if ((rx_word == MARKER) && mk_q) begin
                     // Second marker closes the frame and is not counted.
                     fe_d       = 1'b1;
                     mk_d       = 1'b0;
                     byte_cnt_d = '0;
                  end else begin
                     mk_d       = (rx_word == MARKER);
                     byte_cnt_d = byte_cnt_q + CNT_W'(1);
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end else if (sclk_fall) begin
               if (bit_cnt_q != '0) begin
                  tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
                  miso_d  = tx_sr_q[DATA_W-2];
               end else begin
                  // Falling edge after a completed word: start the next one.
                  tx_sr_d = din;
                  miso_d  = din[DATA_W-1];
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         rx_sr_q    <= '0;
         tx_sr_q    <= '0;
         miso_q     <= 1'b0;
         dout_q     <= '0;
         done_q     <= 1'b0;
         fe_q       <= 1'b0;
         mk_q       <= 1'b0;
         byte_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_sr_q    <= rx_sr_d;
         tx_sr_q    <= tx_sr_d;
         miso_q     <= miso_d;
         dout_q     <= dout_d;
         done_q     <= done_d;
         fe_q       <= fe_d;
         mk_q       <= mk_d;
         byte_cnt_q <= byte_cnt_d;
      end
   end

   assign miso      = miso_q;
   assign dout_iw   = dout_q;
   assign done_iw   = done_q;
   assign frame_end = fe_q;
   assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_ser_spi_iw_rx.sv
// tb/tb_ser_spi_iw_rx.sv - scoreboard bench for ser_spi_iw_rx

module tb_ser_spi_iw_rx;

   logic        clk;
   logic        rst;
   logic        sclk;
   logic        mosi;
   logic        ss;
   logic [7:0]  din;
   logic        miso;
   logic [7:0]  dout_iw;
   logic        done_iw;
   logic        frame_end;
   logic [15:0] byte_cnt;

   ser_spi_iw_rx dut (
      .clk       (clk),
      .rst       (rst),
      .sclk      (sclk),
      .mosi      (mosi),
      .ss        (ss),
      .din       (din),
      .miso      (miso),
      .dout_iw   (dout_iw),
      .done_iw   (done_iw),
      .frame_end (frame_end),
      .byte_cnt  (byte_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  b;
      logic        fe;
      logic [15:0] cnt;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   int          fe_seen  = 0;
   logic        mk_model = 1'b0;
   logic [15:0] cnt_model = 16'd0;
   logic [7:0]  last_byte = 8'd0;
   logic        done_prev = 1'b0;
   logic [7:0]  last_dout = 8'd0;

   // Output monitor: pops the scoreboard on every done_iw strobe.
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         done_prev = 1'b0;
         last_dout = dout_iw;
      end else begin
         if (done_iw === 1'b1) begin
            checks++;
            if (done_prev) begin
               failures++;
               $display("FAIL done_width: done_iw high for 2 cycles, required 1");
            end
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_done: dout_iw=%02h with empty scoreboard", dout_iw);
            end else begin
               exp_t e;
               e = sb.pop_front();
               checks += 3;
               if (dout_iw !== e.b) begin
                  failures++;
                  $display("FAIL dout_iw: got %02h required %02h", dout_iw, e.b);
               end
               if (frame_end !== e.fe) begin
                  failures++;
                  $display("FAIL frame_end: got %b required %b (byte %02h)", frame_end, e.fe, e.b);
               end
               if (byte_cnt !== e.cnt) begin
                  failures++;
                  $display("FAIL byte_cnt_at_done: got %0d required %0d", byte_cnt, e.cnt);
               end
            end
            if (frame_end === 1'b1) fe_seen++;
         end else begin
            checks++;
            if (frame_end !== 1'b0) begin
               failures++;
               $display("FAIL frame_end_alone: got %b required 0 without done_iw", frame_end);
            end
            checks++;
            if (dout_iw !== last_dout) begin
               failures++;
               $display("FAIL dout_stable: got %02h required %02h", dout_iw, last_dout);
            end
         end
         done_prev = done_iw;
         last_dout = dout_iw;
      end
   end

   // Reference model of byte acceptance and marker tracking.
   task automatic push_expected(input logic [7:0] b);
      exp_t e;
      e.b  = b;
      e.fe = (b == 8'd128) && mk_model;
      if (e.fe) cnt_model = 16'd0;
      else      cnt_model = cnt_model + 16'd1;
      mk_model  = (b == 8'd128) && !e.fe;
      e.cnt     = cnt_model;
      last_byte = b;
      sb.push_back(e);
   endtask

   task automatic ss_begin();
      sclk = 1'b0;
      ss   = 1'b0;
      #40;
   endtask

   task automatic ss_end();
      #20;
      ss = 1'b1;
      #60;
   endtask

   // Shifts one full word; host samples miso at the end of each high phase.
   task automatic spi_word(input logic [7:0] b, input logic [7:0] next_din,
                           output logic [7:0] got);
      push_expected(b);
      for (int i = 7; i >= 0; i--) begin
         mosi = b[i];
         #20 sclk = 1'b1;
         if (i == 0) din = next_din;
         #19 got[i] = miso;
         #1 sclk = 1'b0;
      end
   endtask

   task automatic check_idle_sb(input string name);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL %s_pending: %0d bytes not received, required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; din = 8'h00;
      for (int i = 0; i < 8; i++) begin
         #20 sclk = ~sclk; mosi = ~mosi;
      end
      #1;
      checks++;
      if ({dout_iw, done_iw, frame_end, miso, byte_cnt} !== 27'd0) begin
         failures++;
         $display("FAIL reset_outputs: dout=%02h done=%b fe=%b miso=%b cnt=%0d required all 0",
                  dout_iw, done_iw, frame_end, miso, byte_cnt);
      end
      sclk = 1'b0;
      #20 rst = 1'b1;
      for (int i = 0; i < 16; i++) begin
         mosi = i[0];
         #20 sclk = ~sclk;
      end
      #40;
      checks++;
      if (byte_cnt !== 16'd0 || miso !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: cnt=%0d miso=%b required 0 0", byte_cnt, miso);
      end
      check_idle_sb("reset");
   endtask

   task automatic test_single_byte();
      logic [7:0] got;
      din = 8'h3C;
      ss_begin();
      spi_word(8'hA5, 8'h00, got);
      ss_end();
      checks++;
      if (got !== 8'h3C) begin
         failures++;
         $display("FAIL single_miso: got %02h required 3c", got);
      end
      checks++;
      if (byte_cnt !== 16'd1) begin
         failures++;
         $display("FAIL single_cnt: got %0d required 1", byte_cnt);
      end
      checks++;
      if (miso !== 1'b0) begin
         failures++;
         $display("FAIL single_miso_idle: got %b required 0", miso);
      end
      check_idle_sb("single");
   endtask

   task automatic test_back_to_back();
      logic [7:0] g1, g2;
      din = 8'h81;
      ss_begin();
      spi_word(8'h01, 8'h7E, g1);
      spi_word(8'hFE, 8'h00, g2);
      ss_end();
      checks++;
      if (g1 !== 8'h81) begin
         failures++;
         $display("FAIL b2b_miso1: got %02h required 81", g1);
      end
      checks++;
      if (g2 !== 8'h7E) begin
         failures++;
         $display("FAIL b2b_miso2: got %02h required 7e", g2);
      end
      check_idle_sb("b2b");
   endtask

   task automatic test_frame_marker();
      logic [7:0] g;
      int fe0;
      fe0 = fe_seen;
      ss_begin();
      spi_word(8'h05, 8'h00, g);
      spi_word(8'd128, 8'h00, g);
      spi_word(8'd128, 8'h00, g);
      ss_end();
      checks++;
      if (fe_seen - fe0 != 1) begin
         failures++;
         $display("FAIL marker_fe_count: got %0d required 1", fe_seen - fe0);
      end
      checks++;
      if (byte_cnt !== 16'd0) begin
         failures++;
         $display("FAIL marker_cnt_clear: got %0d required 0", byte_cnt);
      end
      ss_begin();
      spi_word(8'd128, 8'h00, g);
      ss_end();
      checks++;
      if (byte_cnt !== 16'd1 || fe_seen - fe0 != 1) begin
         failures++;
         $display("FAIL marker_third: cnt=%0d fe=%0d required 1 1", byte_cnt, fe_seen - fe0);
      end
      check_idle_sb("marker");
   endtask

   task automatic test_marker_broken();
      logic [7:0] g;
      int fe0;
      fe0 = fe_seen;
      ss_begin();
      spi_word(8'h11, 8'h00, g);
      spi_word(8'd128, 8'h00, g);
      spi_word(8'h07, 8'h00, g);
      spi_word(8'd128, 8'h00, g);
      ss_end();
      checks++;
      if (fe_seen != fe0) begin
         failures++;
         $display("FAIL broken_fe: got %0d frame_end required 0", fe_seen - fe0);
      end
      // Marker flag must survive the deselect between transactions.
      ss_begin();
      spi_word(8'd128, 8'h00, g);
      ss_end();
      checks++;
      if (fe_seen - fe0 != 1 || byte_cnt !== 16'd0) begin
         failures++;
         $display("FAIL split_frame: fe=%0d cnt=%0d required 1 0", fe_seen - fe0, byte_cnt);
      end
      check_idle_sb("broken");
   endtask

   task automatic test_abort();
      logic [7:0] g;
      logic [7:0] pat;
      pat = 8'hF0;
      ss_begin();
      for (int i = 7; i >= 3; i--) begin
         mosi = pat[i];
         #20 sclk = 1'b1;
         #20 sclk = 1'b0;
      end
      ss_end();
      checks++;
      if (dout_iw !== last_byte || byte_cnt !== cnt_model) begin
         failures++;
         $display("FAIL abort_hold: dout=%02h cnt=%0d required %02h %0d",
                  dout_iw, byte_cnt, last_byte, cnt_model);
      end
      checks++;
      if (miso !== 1'b0) begin
         failures++;
         $display("FAIL abort_miso: got %b required 0", miso);
      end
      ss_begin();
      spi_word(8'h5A, 8'h00, g);
      ss_end();
      check_idle_sb("abort");
   endtask

   task automatic test_mid_reset();
      logic [7:0] g;
      logic [7:0] pat;
      pat = 8'hFF;
      din = 8'hFF;
      ss_begin();
      for (int i = 7; i >= 4; i--) begin
         mosi = pat[i];
         #20 sclk = 1'b1;
         #20 sclk = 1'b0;
      end
      #20 sclk = 1'b1;
      #7 rst = 1'b0;
      #1;
      checks++;
      if ({dout_iw, done_iw, frame_end, miso, byte_cnt} !== 27'd0) begin
         failures++;
         $display("FAIL midrst_outputs: dout=%02h done=%b fe=%b miso=%b cnt=%0d required all 0",
                  dout_iw, done_iw, frame_end, miso, byte_cnt);
      end
      sclk = 1'b0;
      ss   = 1'b1;
      mk_model  = 1'b0;
      cnt_model = 16'd0;
      last_byte = 8'd0;
      sb.delete();
      #30 rst = 1'b1;
      #40;
      din = 8'h96;
      ss_begin();
      spi_word(8'hC3, 8'h00, g);
      ss_end();
      checks++;
      if (g !== 8'h96 || byte_cnt !== 16'd1) begin
         failures++;
         $display("FAIL midrst_byte: miso=%02h cnt=%0d required 96 1", g, byte_cnt);
      end
      check_idle_sb("midrst");
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_frame_marker();
      test_marker_broken();
      test_abort();
      test_mid_reset();
      #50;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
